// File: rtl/muldiv_ctrl_if.sv
// HI/LO unit bundle: control-unit request/response plus divider and multiplier launch/complete.
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        stall;
  logic        busy;

  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  logic        mult_start;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;

  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        dz_exc;
  logic        to_err;

  // master: the surrounding core (control unit plus the arithmetic units)
  modport master (
    output op_valid, op_code, rs_val, rt_val,
    output div_done, div_hi, div_lo,
    output mult_done, mult_hi, mult_lo,
    input  op_ready, stall, busy,
    input  div_start, div_dividend, div_divisor,
    input  mult_start, mult_a, mult_b,
    input  hi_out, lo_out, rd_data, rd_valid, dz_exc, to_err
  );

  modport slave (
    input  op_valid, op_code, rs_val, rt_val,
    input  div_done, div_hi, div_lo,
    input  mult_done, mult_hi, mult_lo,
    output op_ready, stall, busy,
    output div_start, div_dividend, div_divisor,
    output mult_start, mult_a, mult_b,
    output hi_out, lo_out, rd_data, rd_valid, dz_exc, to_err
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: owns HI/LO, launches divider/multiplier, stalls issue while either runs,
// traps divide-by-zero and aborts a hung unit via a watchdog.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic          clock,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MFHI = 3'd2;
  localparam logic [2:0] OP_MFLO = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DIV  = 2'd1,
    WAIT_MULT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wdog;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             div_start;
  logic             mult_start;
  logic             dz_exc;
  logic             to_err;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic [31:0]      mult_a;
  logic [31:0]      mult_b;

  logic             accept;
  logic             unit_done;
  logic [31:0]      unit_hi;
  logic [31:0]      unit_lo;

  assign accept = bus.op_valid && (state == IDLE);

  // Only the unit we are waiting on may complete the operation.
  always_comb begin
    unit_done = 1'b0;
    unit_hi   = 32'd0;
    unit_lo   = 32'd0;
    case (state)
      WAIT_DIV: begin
        unit_done = bus.div_done;
        unit_hi   = bus.div_hi;
        unit_lo   = bus.div_lo;
      end
      WAIT_MULT: begin
        unit_done = bus.mult_done;
        unit_hi   = bus.mult_hi;
        unit_lo   = bus.mult_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      wdog         <= '0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      rd_data      <= 32'd0;
      rd_valid     <= 1'b0;
      div_start    <= 1'b0;
      mult_start   <= 1'b0;
      dz_exc       <= 1'b0;
      to_err       <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      mult_a       <= 32'd0;
      mult_b       <= 32'd0;
    end else begin
      rd_valid   <= 1'b0;
      div_start  <= 1'b0;
      mult_start <= 1'b0;
      dz_exc     <= 1'b0;
      to_err     <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.op_code)
              OP_MTHI: hi <= bus.rs_val;
              OP_MTLO: lo <= bus.rs_val;
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              OP_DIV: begin
                if (bus.rt_val == 32'd0) begin
                  dz_exc <= 1'b1;
                end else begin
                  div_dividend <= bus.rs_val;
                  div_divisor  <= bus.rt_val;
                  div_start    <= 1'b1;
                  wdog         <= '0;
                  state        <= WAIT_DIV;
                end
              end
              OP_MULT: begin
                mult_a     <= bus.rs_val;
                mult_b     <= bus.rt_val;
                mult_start <= 1'b1;
                wdog       <= '0;
                state      <= WAIT_MULT;
              end
              default: ;
            endcase
          end
        end

        WAIT_DIV, WAIT_MULT: begin
          // A done seen with wdog==0 is left over from the previous operation.
          if (unit_done && (wdog != '0)) begin
            hi    <= unit_hi;
            lo    <= unit_lo;
            wdog  <= '0;
            state <= IDLE;
          end else if (wdog == WDOG_LAST) begin
            to_err <= 1'b1;
            wdog   <= '0;
            state  <= IDLE;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        default: begin
          wdog  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready     = (state == IDLE);
  assign bus.stall        = bus.op_valid && (state != IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.div_start    = div_start;
  assign bus.div_dividend = div_dividend;
  assign bus.div_divisor  = div_divisor;
  assign bus.mult_start   = mult_start;
  assign bus.mult_a       = mult_a;
  assign bus.mult_b       = mult_b;
  assign bus.hi_out       = hi;
  assign bus.lo_out       = lo;
  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.dz_exc       = dz_exc;
  assign bus.to_err       = to_err;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO unit of the MIPS core. It accepts MULT/DIV/MFHI/MFLO/MTHI/MTLO operations from the control unit and owns the architectural HI/LO registers. It launches the multi-cycle divider or multiplier and stalls the issuing stage while either is busy. It also screens divide-by-zero and guards against a hung unit with a watchdog.

Parameters:
TIMEOUT, 40, max cycles in a WAIT state before abort (the divider needs about 33 cycles).
CNT_W, 6, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
op_valid  in  1  operation request.
op_code  in  3  0=MULT, 1=DIV, 2=MFHI, 3=MFLO, 4=MTHI, 5=MTLO; 6 and 7 are ignored (accepted as no-op).
rs_val  in  32  dividend / multiplicand / MTHI-MTLO source.
rt_val  in  32  divisor / multiplier.
op_ready  out  1  high only in IDLE; a request is accepted when op_valid && op_ready.
stall  out  1  op_valid && !op_ready (combinational).
busy  out  1  state != IDLE.
div_start  out  1  one-cycle launch pulse to the divider.
div_dividend  out  32  registered, stable for the whole operation.
div_divisor  out  32  registered, stable for the whole operation.
div_done  in  1  divider completion pulse.
div_hi  in  32  divider remainder.
div_lo  in  32  divider quotient.
mult_start  out  1  one-cycle launch pulse to the multiplier.
mult_a  out  32  registered multiplier operand.
mult_b  out  32  registered multiplier operand.
mult_done  in  1  multiplier completion pulse.
mult_hi  in  32  multiplier product high word.
mult_lo  in  32  multiplier product low word.
hi_out  out  32  architectural HI.
lo_out  out  32  architectural LO.
rd_data  out  32  MFHI/MFLO result.
rd_valid  out  1  one-cycle pulse qualifying rd_data.
dz_exc  out  1  one-cycle divide-by-zero pulse.
to_err  out  1  one-cycle watchdog-abort pulse.

Behaviour:
- Reset values:
  - hi_out, lo_out, rd_data, all operand registers = 0.
  - rd_valid, div_start, mult_start, dz_exc, to_err, busy = 0.
  - State = IDLE, watchdog = 0, op_ready = 1.
- States:
  - IDLE: the only state that accepts requests.
  - WAIT_DIV: divider running.
  - WAIT_MULT: multiplier running.
- IDLE, per accepted op_code (effect appears the next cycle):
  - MTHI: hi_out <= rs_val.
  - MTLO: lo_out <= rs_val.
  - MFHI: rd_data <= hi_out, rd_valid pulses.
  - MFLO: rd_data <= lo_out, rd_valid pulses.
  - These ops are back-to-back capable: MTHI followed by MFHI on the next cycle returns the new value.
- DIV:
  - If rt_val==0: no launch, dz_exc pulses one cycle, HI/LO unchanged, remain in IDLE.
  - Else: latch the operands, div_start=1 for exactly the next cycle (so the divider's falling-edge sample sees it), go to WAIT_DIV, watchdog=0.
- MULT: latch the operands, mult_start pulses one cycle, go to WAIT_MULT, watchdog=0.
- WAIT_x:
  - The watchdog increments every cycle.
  - x_done is ignored in the launch cycle (watchdog==0), because the unit may still show a stale done from a previous operation.
  - The first x_done with watchdog>=1 causes {hi_out, lo_out} <= {x_hi, x_lo} and a return to IDLE.
  - If the watchdog reaches TIMEOUT with no done: to_err pulses, HI/LO unchanged, return to IDLE.
- Simultaneous events:
  - A request arriving in the done cycle is stalled (op_ready=0) and accepted the following cycle, so MFHI/MFLO always see the completed result.
  - The watchdog is not checked in the cycle that done arrives.
- Reset mid-operation: abort immediately to reset values, no result write, no error pulse. The divider and multiplier share the same reset.
- All results are passed through unmodified. Signed semantics (truncating quotient, remainder takes the dividend's sign) belong to the arithmetic units.

Test Plan:
- Reset with reset=0 for 2 cycles -> all outputs at reset values, op_ready=1, busy=0.
- MTHI rs=0xDEADBEEF, then MFHI -> hi_out=0xDEADBEEF one cycle after MTHI; rd_data=0xDEADBEEF with rd_valid high for 1 cycle.
- DIV rs=100, rt=7 with the divider model -> div_start is a 1-cycle pulse; stall held during the run; after div_done, lo_out=14, hi_out=2; MFLO issued mid-run is held, then returns 14.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then DIV rt=0 -> dz_exc 1-cycle pulse, no div_start, HI/LO unchanged, busy stays 0.
- MULT with a model whose done never arrives -> to_err pulses exactly TIMEOUT cycles after launch, state back to IDLE, HI/LO unchanged. A stale done in the launch cycle is ignored.
- Reset asserted 10 cycles into a DIV -> next cycle busy=0 and HI/LO=0; a later div_done pulse has no effect.
